// File: rtl/msrv32_iadder_arbiter_pkg.sv
// msrv32_pkg: shared constants and helpers for the immediate-adder arbiter
// Provides XLEN, requester IDs, adder source selects and the misalignment rule.
package msrv32_pkg;
   localparam int XLEN = 32;
   localparam logic REQ_BR = 1'b0;
   localparam logic REQ_LS = 1'b1;
   localparam logic IADDER_SRC_PC = 1'b0;
   localparam logic IADDER_SRC_RS1 = 1'b1;
   // Branch targets must be word aligned; JALR only checks bit 1 since bit 0 is cleared
   function automatic logic misaligned(input logic id, input logic jalr, input logic [1:0] lsb);
      return (id == REQ_BR) ? |lsb : (jalr & lsb[1]);
   endfunction
endpackage

// File: rtl/msrv32_iadder_arbiter_if.sv
// msrv32_iadder_arbiter_if: request, adder and result signals of the adder arbiter
// slave: arbiter side; master: requesters, adder and result consumer side.
interface msrv32_iadder_arbiter_if;
   import msrv32_pkg::*;
   logic br_valid_in, br_ready_out;
   logic [XLEN-1:0] br_pc_in, br_imm_in;
   logic ls_valid_in, ls_ready_out, ls_jalr_in;
   logic [XLEN-1:0] ls_rs_1_in, ls_imm_in;
   logic [XLEN-1:0] rs_1_out, pc_out, imm_out, iadder_in;
   logic iadder_src_out;
   logic res_valid_out, res_ready_in, res_id_out, res_misaligned_out;
   logic [XLEN-1:0] res_addr_out;
   modport slave (
      input br_valid_in, br_pc_in, br_imm_in, ls_valid_in, ls_rs_1_in, ls_imm_in, ls_jalr_in,
         iadder_in, res_ready_in,
      output br_ready_out, ls_ready_out, rs_1_out, pc_out, imm_out, iadder_src_out,
         res_valid_out, res_addr_out, res_id_out, res_misaligned_out
   );
   modport master (
      output br_valid_in, br_pc_in, br_imm_in, ls_valid_in, ls_rs_1_in, ls_imm_in, ls_jalr_in,
         iadder_in, res_ready_in,
      input br_ready_out, ls_ready_out, rs_1_out, pc_out, imm_out, iadder_src_out,
         res_valid_out, res_addr_out, res_id_out, res_misaligned_out
   );
endinterface

// File: rtl/msrv32_rr_arb2.sv
// msrv32_rr_arb2: two-way grant with last-grant register
// Ports: clk_i, rst_i; req_br_i/req_ls_i requests; xfer_i grant accepted; grant_o winner.
module msrv32_rr_arb2 import msrv32_pkg::*; #(parameter bit RR_EN = 1'b1) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic req_br_i,
   input  logic req_ls_i,
   input  logic xfer_i,
   output logic grant_o
);
   logic last_grant_q, last_grant_d;
   // Resetting last_grant to LS makes the branch unit win the first contention
   assign grant_o = (req_br_i & req_ls_i) ? (RR_EN ? ~last_grant_q : REQ_BR) : (req_ls_i ? REQ_LS : REQ_BR);
   assign last_grant_d = xfer_i ? grant_o : last_grant_q;
   always_ff @(posedge clk_i)
      last_grant_q <= rst_i ? REQ_LS : last_grant_d;
endmodule

// File: rtl/msrv_32_imm_adder.sv
// msrv_32_imm_adder: immediate adder, (rs1 or PC) + imm
// Ports: pc_in, rs_1_in, imm_in operands; iadder_src_in 1 = rs1; iadder_out sum.
module msrv_32_imm_adder import msrv32_pkg::*; (
   input  logic [XLEN-1:0] pc_in,
   input  logic [XLEN-1:0] rs_1_in,
   input  logic [XLEN-1:0] imm_in,
   input  logic            iadder_src_in,
   output logic [XLEN-1:0] iadder_out
);
   assign iadder_out = ((iadder_src_in == IADDER_SRC_RS1) ? rs_1_in : pc_in) + imm_in;
endmodule

// File: rtl/msrv32_iadder_arbiter.sv
// msrv32_iadder_arbiter: shares the immediate adder between branch unit and LSU/JALR
// Ports: ms_riscv32_mp_clk_in, ms_riscv32_mp_rst_in (sync, active-high);
// bus: requests, adder operand drive, registered result with valid/ready and ID.
module msrv32_iadder_arbiter import msrv32_pkg::*; #(parameter bit RR_EN = 1'b1) (
   input logic ms_riscv32_mp_clk_in,
   input logic ms_riscv32_mp_rst_in,
   msrv32_iadder_arbiter_if.slave bus
);
   logic grant, any, slot_free, xfer, jalr, use_br, use_ls;
   logic res_valid_q, res_valid_d, res_id_q, res_id_d, res_mis_q, res_mis_d;
   logic [XLEN-1:0] res_addr_q, res_addr_d;
   msrv32_rr_arb2 #(.RR_EN(RR_EN)) u_arb (
      .clk_i(ms_riscv32_mp_clk_in),
      .rst_i(ms_riscv32_mp_rst_in),
      .req_br_i(bus.br_valid_in),
      .req_ls_i(bus.ls_valid_in),
      .xfer_i(xfer),
      .grant_o(grant)
   );
   assign any = bus.br_valid_in | bus.ls_valid_in;
   assign use_br = any & (grant == REQ_BR);
   assign use_ls = any & (grant == REQ_LS);
   assign slot_free = ~res_valid_q | bus.res_ready_in;
   assign bus.br_ready_out = ~ms_riscv32_mp_rst_in & bus.br_valid_in & (grant == REQ_BR) & slot_free;
   assign bus.ls_ready_out = ~ms_riscv32_mp_rst_in & bus.ls_valid_in & (grant == REQ_LS) & slot_free;
   assign xfer = bus.br_ready_out | bus.ls_ready_out;
   assign jalr = use_ls & bus.ls_jalr_in;
   // Idle operands are held at zero so the adder does not toggle
   assign bus.iadder_src_out = use_ls ? IADDER_SRC_RS1 : IADDER_SRC_PC;
   assign bus.pc_out = use_br ? bus.br_pc_in : '0;
   assign bus.rs_1_out = use_ls ? bus.ls_rs_1_in : '0;
   assign bus.imm_out = use_ls ? bus.ls_imm_in : (use_br ? bus.br_imm_in : '0);
   assign res_valid_d = xfer | (res_valid_q & ~bus.res_ready_in);
   assign res_addr_d = xfer ? (bus.iadder_in & ~XLEN'(jalr)) : res_addr_q;
   assign res_id_d = xfer ? grant : res_id_q;
   assign res_mis_d = xfer ? misaligned(grant, jalr, bus.iadder_in[1:0]) : res_mis_q;
   always_ff @(posedge ms_riscv32_mp_clk_in) begin
      if (ms_riscv32_mp_rst_in) begin
         res_valid_q <= 1'b0;
         res_addr_q <= '0;
         res_id_q <= REQ_BR;
         res_mis_q <= 1'b0;
      end else begin
         res_valid_q <= res_valid_d;
         res_addr_q <= res_addr_d;
         res_id_q <= res_id_d;
         res_mis_q <= res_mis_d;
      end
   end
   assign bus.res_valid_out = res_valid_q;
   assign bus.res_addr_out = res_addr_q;
   assign bus.res_id_out = res_id_q;
   assign bus.res_misaligned_out = res_mis_q;
endmodule

// File: tb/tb_msrv32_iadder_arbiter.sv
// tb_msrv32_iadder_arbiter: directed and random checks of round-robin and fixed-priority arbiters
module tb_msrv32_iadder_arbiter;
   logic clk = 1'b0, rst = 1'b1;
   logic brv = 0, lsv = 0, jalr = 0, rrdy = 0;
   logic [31:0] brpc = 0, brimm = 0, lsrs1 = 0, lsimm = 0, held;
   int checks = 0, errors = 0;
   logic mv[2], mid[2], mm[2], ml[2];
   logic [31:0] ma[2];
   logic [1:0] o_brr, o_lsr, o_val, o_id, o_mis;
   logic [31:0] o_addr[2];
   always #5 clk = ~clk;
   msrv32_iadder_arbiter_if b0 ();
   msrv32_iadder_arbiter_if b1 ();
   assign b0.br_valid_in = brv;
   assign b0.br_pc_in = brpc;
   assign b0.br_imm_in = brimm;
   assign b0.ls_valid_in = lsv;
   assign b0.ls_rs_1_in = lsrs1;
   assign b0.ls_imm_in = lsimm;
   assign b0.ls_jalr_in = jalr;
   assign b0.res_ready_in = rrdy;
   assign b1.br_valid_in = brv;
   assign b1.br_pc_in = brpc;
   assign b1.br_imm_in = brimm;
   assign b1.ls_valid_in = lsv;
   assign b1.ls_rs_1_in = lsrs1;
   assign b1.ls_imm_in = lsimm;
   assign b1.ls_jalr_in = jalr;
   assign b1.res_ready_in = rrdy;
   msrv32_iadder_arbiter #(.RR_EN(1'b1)) dut_rr (.ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst), .bus(b0));
   msrv32_iadder_arbiter #(.RR_EN(1'b0)) dut_fp (.ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst), .bus(b1));
   msrv_32_imm_adder add0 (.pc_in(b0.pc_out), .rs_1_in(b0.rs_1_out), .imm_in(b0.imm_out),
      .iadder_src_in(b0.iadder_src_out), .iadder_out(b0.iadder_in));
   msrv_32_imm_adder add1 (.pc_in(b1.pc_out), .rs_1_in(b1.rs_1_out), .imm_in(b1.imm_out),
      .iadder_src_in(b1.iadder_src_out), .iadder_out(b1.iadder_in));
   assign o_brr = {b1.br_ready_out, b0.br_ready_out};
   assign o_lsr = {b1.ls_ready_out, b0.ls_ready_out};
   assign o_val = {b1.res_valid_out, b0.res_valid_out};
   assign o_id = {b1.res_id_out, b0.res_id_out};
   assign o_mis = {b1.res_misaligned_out, b0.res_misaligned_out};
   assign o_addr[0] = b0.res_addr_out;
   assign o_addr[1] = b1.res_addr_out;

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, o, e);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         mv[k] = 0; ma[k] = 0; mid[k] = 0; mm[k] = 0; ml[k] = 1;
      end
   endtask

   // One clock: check outputs at the falling edge against the model, then advance the model
   task automatic cycle();
      logic g, rb, rl, mis;
      logic [31:0] s;
      logic nv[2], nid[2], nm[2], nl[2];
      logic [31:0] na[2];
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         // k=0 alternates on contention (winner is whoever did not win last), k=1 always favours branch
         if (brv && lsv) g = (k == 0) ? !ml[k] : 1'b0;
         else g = lsv;
         rb = !rst && brv && !g && (!mv[k] || rrdy);
         rl = !rst && lsv && g && (!mv[k] || rrdy);
         chk($sformatf("br_ready%0d", k), 32'(o_brr[k]), 32'(rb));
         chk($sformatf("ls_ready%0d", k), 32'(o_lsr[k]), 32'(rl));
         chk($sformatf("res_valid%0d", k), 32'(o_val[k]), 32'(mv[k]));
         chk($sformatf("res_addr%0d", k), o_addr[k], ma[k]);
         chk($sformatf("res_id%0d", k), 32'(o_id[k]), 32'(mid[k]));
         chk($sformatf("res_mis%0d", k), 32'(o_mis[k]), 32'(mm[k]));
         if (g) begin
            s = lsrs1 + lsimm;
            mis = jalr && s[1];
            if (jalr) s[0] = 1'b0;
         end else begin
            s = brpc + brimm;
            mis = (s % 4) != 0;
         end
         nv[k] = mv[k]; na[k] = ma[k]; nid[k] = mid[k]; nm[k] = mm[k]; nl[k] = ml[k];
         if (rst) begin
            nv[k] = 0; na[k] = 0; nid[k] = 0; nm[k] = 0; nl[k] = 1;
         end else if (rb || rl) begin
            nv[k] = 1; na[k] = s; nid[k] = g; nm[k] = mis; nl[k] = g;
         end else if (rrdy) nv[k] = 0;
      end
      if (brv || lsv) begin
         if (brv && lsv) g = !ml[0];
         else g = lsv;
         chk("drive_src", 32'(b0.iadder_src_out), 32'(g));
         chk("drive_imm", b0.imm_out, g ? lsimm : brimm);
         chk("drive_pc", b0.pc_out, g ? 32'h0 : brpc);
         chk("drive_rs1", b0.rs_1_out, g ? lsrs1 : 32'h0);
      end else begin
         chk("idle_ops", b0.pc_out | b0.rs_1_out | b0.imm_out | 32'(b0.iadder_src_out), 32'h0);
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         mv[k] = nv[k]; ma[k] = na[k]; mid[k] = nid[k]; mm[k] = nm[k]; ml[k] = nl[k];
      end
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      brv = 1;
      cycle();
      chk("reset_valid", 32'(b0.res_valid_out), 0);
      chk("reset_addr", b0.res_addr_out, 0);
      rst = 0;
      // Branch only
      brpc = 32'h0001_0000; brimm = 32'h0000_0010; rrdy = 1;
      cycle();
      brv = 0;
      chk("t1_valid", 32'(b0.res_valid_out), 1);
      chk("t1_addr", b0.res_addr_out, 32'h0001_0010);
      chk("t1_id", 32'(b0.res_id_out), 0);
      chk("t1_mis", 32'(b0.res_misaligned_out), 0);
      // JALR clears bit 0
      lsv = 1; lsrs1 = 32'hAABB_CCDD; lsimm = 32'h0000_0004; jalr = 1;
      cycle();
      lsv = 0;
      chk("t2_addr", b0.res_addr_out, 32'hAABB_CCE0);
      chk("t2_id", 32'(b0.res_id_out), 1);
      chk("t2_mis", 32'(b0.res_misaligned_out), 0);
      // Contention every cycle
      brv = 1; lsv = 1; jalr = 0;
      for (int i = 0; i < 4; i++) begin
         cycle();
         chk("t3_rr_id", 32'(b0.res_id_out), i % 2);
         chk("t3_fp_id", 32'(b1.res_id_out), 0);
      end
      // Back-pressure
      lsv = 0; rrdy = 0;
      held = b0.res_addr_out;
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("t4_hold_addr", b0.res_addr_out, held);
         chk("t4_hold_rdy", 32'(b0.br_ready_out), 0);
      end
      rrdy = 1;
      #1;
      chk("t4_drain_rdy", 32'(b0.br_ready_out), 1);
      cycle();
      // Misaligned branch and wrap-around
      brpc = 32'h0001_0000; brimm = 32'h0000_0002;
      cycle();
      chk("t5_addr", b0.res_addr_out, 32'h0001_0002);
      chk("t5_mis", 32'(b0.res_misaligned_out), 1);
      brv = 0; lsv = 1; lsrs1 = 32'hFFFF_FFFC; lsimm = 32'h0000_0008;
      cycle();
      chk("t5_wrap", b0.res_addr_out, 32'h0000_0004);
      // Reset while a result is held
      lsv = 0; brv = 1; rrdy = 0;
      cycle();
      rst = 1;
      #1;
      chk("t6_rst_rdy", 32'(b0.br_ready_out), 0);
      cycle();
      chk("t6_valid", 32'(b0.res_valid_out), 0);
      rst = 0; lsv = 1; rrdy = 1;
      #1;
      chk("t6_br_first", 32'(b0.br_ready_out), 1);
      chk("t6_ls_wait", 32'(b0.ls_ready_out), 0);
      cycle();
      chk("t6_id", 32'(b0.res_id_out), 0);
      // Random traffic
      for (int i = 0; i < 400; i++) begin
         rst = ($urandom_range(0, 49) == 0);
         brv = 1'($urandom_range(0, 1));
         lsv = 1'($urandom_range(0, 1));
         jalr = 1'($urandom_range(0, 1));
         rrdy = ($urandom_range(0, 3) != 0);
         brpc = $urandom; brimm = $urandom;
         lsrs1 = $urandom; lsimm = $urandom;
         if ($urandom_range(0, 1) == 1) brimm = 32'($urandom_range(0, 7));
         cycle();
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
